ship_place_ctrl: RTL
====================

Name: ship_place_ctrl

Overview:
Sequences all board-RAM accesses needed to check and place one ship on the 10x10 own-ship grid.
- PicoBlaze firmware supplies the origin, orientation, length and mode through the I/O interface. The block performs bounds checks, per-cell occupancy reads and optional cell writes.
- It returns a single valid/invalid result.
- It also arbitrates the board RAM port between the placement sequence and the remote-guess lookup requester (XBee side).

Parameters:
GRID_DIM, 10, cells per row/column; legal row/col range is 0..GRID_DIM-1.
MAX_LEN, 5, longest legal ship length.
RAM_LAT, 1, board-RAM read latency in cycles (1 or 2).
CELL_W, 2, board-RAM data width.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
place  in  1  0 = check only, 1 = check then write cells
origin  in  8  {row[7:4], col[3:0]} of ship head
orient  in  1  0 = horizontal (col increments), 1 = vertical (row increments)
ship_len  in  3  ship length, 1..MAX_LEN
wr_val  in  CELL_W  value written to each cell in place mode
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse, result valid
valid  out  1  result: 1 = all cells in bounds and empty
probe_req  in  1  remote-guess lookup request (level, held until ack)
probe_addr  in  8  {row, col} to look up
probe_ack  out  1  one-cycle pulse; probe_data valid
probe_data  out  CELL_W  cell contents for probe
ram_addr  out  8  board-RAM address
ram_we  out  1  board-RAM write enable
ram_wdata  out  CELL_W  board-RAM write data
ram_rdata  in  CELL_W  board-RAM read data, RAM_LAT cycles after address

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; index counter 0.
- States: IDLE, BOUND, RD, WT, EVAL, WR, DONE, PRB, PRB_WT.
- IDLE transitions:
  - probe_req=1 goes to PRB. Probe has priority over start in the same cycle; that start is dropped and is not queued.
  - Otherwise start=1 latches place, origin, orient, ship_len, wr_val. busy rises next cycle; go to BOUND, index i=0.
- BOUND:
  - Compute cell i: horizontal addr={row, col+i}, vertical addr={row+i, col}.
  - Sums are 5 bits wide, so no wrap-around.
  - If the incremented coordinate or the fixed coordinate is >= GRID_DIM, or ship_len is 0 or > MAX_LEN, set fail and go to DONE.
  - Else go to RD.
- RD: drive ram_addr=cell address, ram_we=0. Go to WT when RAM_LAT=2, else to EVAL.
- EVAL:
  - Sample ram_rdata. If nonzero, set fail and go to DONE.
  - Else, if i==ship_len-1: go to WR with i=0 when place=1, else go to DONE.
  - Else i++ and go to BOUND.
  - Net cost per cell is 3+(RAM_LAT-1) cycles.
- WR: drive ram_addr=cell i, ram_we=1, ram_wdata=wr_val for one cycle each. i++ until i==ship_len-1, then DONE. Writes occur only after every cell has passed; a failed check writes nothing.
- DONE:
  - Pulse done for one cycle; valid = ~fail; busy falls the same cycle.
  - valid holds its value until the next accepted start, then clears to 0.
  - Return to IDLE.
- PRB: drive ram_addr=probe_addr, ram_we=0. Wait RAM_LAT cycles (PRB_WT when RAM_LAT=2), then capture probe_data and pulse probe_ack. Return to IDLE.
- Arbitration:
  - A probe arriving while a sequence is busy waits until IDLE.
  - start asserted while busy is ignored.
  - ram_we is 1 only in WR.
- ram_addr holds its last value when not driven.
- Asserting reset_n low mid-sequence aborts immediately: no done pulse, and no further writes.

Decomposition:
- Shared package `battleship_pkg`: GRID_DIM, MAX_LEN, CELL_W, cell codes (EMPTY=0, SHIP=1, HIT=2, MISS=3), and the FSM state encoding.
- One natural sub-module: `cell_addr_gen`. It is combinational and computes the cell address and the out-of-bounds flag from origin, orient and i.

Test Plan:
- Empty RAM; start, place=0, origin=0x23, orient=0, len=3 → reads 0x23, 0x24, 0x25; done with valid=1; no writes; done 10 cycles after start (RAM_LAT=1).
- Empty RAM; place=1, origin=0x50, orient=1, len=4, wr_val=1 → writes to 0x50, 0x60, 0x70, 0x80 with data 1; valid=1.
- RAM[0x35]=1; place=1, origin=0x33, orient=0, len=4 → read stops at 0x35; valid=0; zero write cycles.
- origin=0x07, orient=0, len=4 → cell 0x0A is out of bounds; done with valid=0 after reading only 0x07..0x09.
- probe_req and start in the same IDLE cycle with probe_addr=0x44, RAM[0x44]=2 → probe_ack with probe_data=2; start dropped; busy stays 0.
- reset_n low during WR of a len-5 placement → outputs 0 immediately; remaining cells are unwritten; FSM in IDLE after release.

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared board constants, cell codes and the placement-controller state encoding.
package battleship_pkg;

  localparam int GRID_DIM = 10;
  localparam int MAX_LEN  = 5;
  localparam int CELL_W   = 2;

  localparam logic [CELL_W-1:0] CELL_EMPTY = 2'd0;
  localparam logic [CELL_W-1:0] CELL_SHIP  = 2'd1;
  localparam logic [CELL_W-1:0] CELL_HIT   = 2'd2;
  localparam logic [CELL_W-1:0] CELL_MISS  = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_BOUND  = 4'd1,
    ST_RD     = 4'd2,
    ST_WT     = 4'd3,
    ST_EVAL   = 4'd4,
    ST_WR     = 4'd5,
    ST_DONE   = 4'd6,
    ST_PRB    = 4'd7,
    ST_PRB_WT = 4'd8
  } state_e;

endpackage

// File: rtl/cell_addr_gen.sv
// Combinational cell address for ship cell idx, plus out-of-grid flag.
module cell_addr_gen
  import battleship_pkg::*;
(
  input  logic [7:0] origin,
  input  logic       orient,
  input  logic [2:0] idx,
  output logic [7:0] addr,
  output logic       oob
);

  logic [4:0] row_sum;
  logic [4:0] col_sum;

  // 5-bit sums never wrap, so an overflow past the grid edge is always caught.
  always_comb begin
    row_sum = {1'b0, origin[7:4]} + (orient ? {2'b00, idx} : 5'd0);
    col_sum = {1'b0, origin[3:0]} + (orient ? 5'd0 : {2'b00, idx});
    addr    = {row_sum[3:0], col_sum[3:0]};
    oob     = (row_sum >= 5'(GRID_DIM)) || (col_sum >= 5'(GRID_DIM));
  end

endmodule

// File: rtl/ship_place_ctrl.sv
// Checks (and optionally places) one ship on the own-ship board RAM and
// shares the RAM port with the remote-guess probe requester.
//
// Probe handshake: probe_req is a level the requester holds (with a stable
// probe_addr) until it sees probe_ack; probe_ack is a one-cycle pulse during
// which probe_data is valid. A probe is only serviced from IDLE and beats a
// same-cycle start, which is then dropped.
module ship_place_ctrl
  import battleship_pkg::*;
#(
  parameter int RAM_LAT = 1
)(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              place,
  input  logic [7:0]        origin,
  input  logic              orient,
  input  logic [2:0]        ship_len,
  input  logic [CELL_W-1:0] wr_val,
  output logic              busy,
  output logic              done,
  output logic              valid,
  input  logic              probe_req,
  input  logic [7:0]        probe_addr,
  output logic              probe_ack,
  output logic [CELL_W-1:0] probe_data,
  output logic [7:0]        ram_addr,
  output logic              ram_we,
  output logic [CELL_W-1:0] ram_wdata,
  input  logic [CELL_W-1:0] ram_rdata,
  output logic [3:0]        state_dbg
);

  state_e            state_q, state_d;
  logic [2:0]        i_q, i_d;
  logic              place_q, place_d;
  logic [7:0]        origin_q, origin_d;
  logic              orient_q, orient_d;
  logic [2:0]        len_q, len_d;
  logic [CELL_W-1:0] wr_val_q, wr_val_d;
  logic              fail_q, fail_d;
  logic              valid_q, valid_d;
  logic [7:0]        addr_q, addr_d;
  logic              cap_q, cap_d;
  logic [CELL_W-1:0] probe_data_q, probe_data_d;

  logic [7:0] cell_addr;
  logic       cell_oob;
  logic       len_bad;
  logic       last_cell;

  cell_addr_gen u_cell_addr_gen (
    .origin (origin_q),
    .orient (orient_q),
    .idx    (i_q),
    .addr   (cell_addr),
    .oob    (cell_oob)
  );

  assign len_bad   = (len_q == 3'd0) || (len_q > 3'(MAX_LEN));
  assign last_cell = (i_q == len_q - 3'd1);
  assign state_dbg = state_q;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; cap_q masks the request that is being acknowledged.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (probe_req && !cap_q) state_d = ST_PRB;
                 else if (start)          state_d = ST_BOUND;
      ST_BOUND:  state_d = (cell_oob || len_bad) ? ST_DONE : ST_RD;
      ST_RD:     state_d = (RAM_LAT == 2) ? ST_WT : ST_EVAL;
      ST_WT:     state_d = ST_EVAL;
      ST_EVAL:   if (ram_rdata != '0) state_d = ST_DONE;
                 else if (last_cell)  state_d = place_q ? ST_WR : ST_DONE;
                 else                 state_d = ST_BOUND;
      ST_WR:     state_d = last_cell ? ST_DONE : ST_WR;
      ST_DONE:   state_d = ST_IDLE;
      ST_PRB:    state_d = (RAM_LAT == 2) ? ST_PRB_WT : ST_IDLE;
      ST_PRB_WT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath register: request latches, cell index, result and probe capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_q          <= '0;
      place_q      <= 1'b0;
      origin_q     <= '0;
      orient_q     <= 1'b0;
      len_q        <= '0;
      wr_val_q     <= '0;
      fail_q       <= 1'b0;
      valid_q      <= 1'b0;
      addr_q       <= '0;
      cap_q        <= 1'b0;
      probe_data_q <= '0;
    end else begin
      i_q          <= i_d;
      place_q      <= place_d;
      origin_q     <= origin_d;
      orient_q     <= orient_d;
      len_q        <= len_d;
      wr_val_q     <= wr_val_d;
      fail_q       <= fail_d;
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      cap_q        <= cap_d;
      probe_data_q <= probe_data_d;
    end
  end

  // Datapath next values.
  always_comb begin
    i_d          = i_q;
    place_d      = place_q;
    origin_d     = origin_q;
    orient_d     = orient_q;
    len_d        = len_q;
    wr_val_d     = wr_val_q;
    fail_d       = fail_q;
    valid_d      = valid_q;
    addr_d       = ram_addr;
    cap_d        = 1'b0;
    probe_data_d = cap_q ? ram_rdata : probe_data_q;
    case (state_q)
      ST_IDLE: begin
        if (state_d == ST_BOUND) begin
          place_d  = place;
          origin_d = origin;
          orient_d = orient;
          len_d    = ship_len;
          wr_val_d = wr_val;
          i_d      = '0;
          fail_d   = 1'b0;
          valid_d  = 1'b0;
        end
      end
      ST_BOUND:  if (cell_oob || len_bad) fail_d = 1'b1;
      ST_EVAL: begin
        if (ram_rdata != '0) fail_d = 1'b1;
        else if (last_cell)  i_d = '0;
        else                 i_d = i_q + 3'd1;
      end
      ST_WR:     if (!last_cell) i_d = i_q + 3'd1;
      ST_DONE:   valid_d = ~fail_q;
      ST_PRB:    cap_d = (RAM_LAT != 2);
      ST_PRB_WT: cap_d = 1'b1;
      default: ;
    endcase
  end

  // Outputs decoded from state; ram_addr holds its last value when idle.
  always_comb begin
    busy       = (state_q == ST_BOUND) || (state_q == ST_RD) || (state_q == ST_WT) ||
                 (state_q == ST_EVAL)  || (state_q == ST_WR);
    done       = (state_q == ST_DONE);
    valid      = (state_q == ST_DONE) ? ~fail_q : valid_q;
    ram_we     = (state_q == ST_WR);
    ram_wdata  = (state_q == ST_WR) ? wr_val_q : '0;
    probe_ack  = cap_q;
    probe_data = cap_q ? ram_rdata : probe_data_q;
    case (state_q)
      ST_RD, ST_WR: ram_addr = cell_addr;
      ST_PRB:       ram_addr = probe_addr;
      default:      ram_addr = addr_q;
    endcase
  end

endmodule
